// File: rtl/instruction_ram_loader_pkg.sv
// instruction_ram_loader_pkg: shared loader FSM encoding and stream framing constants
package instruction_ram_loader_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_HI,
      S_HDR_LO,
      S_COLLECT,
      S_WRITE,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;

   function automatic logic accepts_bytes(input state_t s);
      return s inside {S_HDR_HI, S_HDR_LO, S_COLLECT, S_CHECK};
   endfunction

   function automatic logic is_busy(input state_t s);
      return s inside {S_HDR_HI, S_HDR_LO, S_COLLECT, S_WRITE, S_CHECK};
   endfunction
endpackage

// File: rtl/instruction_ram_loader_if.sv
// instruction_ram_loader_if: byte stream, RAM write port and status of the loader
interface instruction_ram_loader_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  start;
   logic [7:0]            byte_in;
   logic                  byte_valid;
   logic                  byte_ready;
   logic                  wr_enable;
   logic [ADDR_WIDTH-1:0] wr_address;
   logic [31:0]           wr_data;
   logic                  busy;
   logic                  done;
   logic                  error;
   logic [ADDR_WIDTH-1:0] words_loaded;

   modport slave (
      input  start, byte_in, byte_valid,
      output byte_ready, wr_enable, wr_address, wr_data, busy, done, error, words_loaded
   );

   modport master (
      output start, byte_in, byte_valid,
      input  byte_ready, wr_enable, wr_address, wr_data, busy, done, error, words_loaded
   );
endinterface

// File: rtl/instruction_ram_loader_byte_word_assembler.sv
// byte_word_assembler: shifts big-endian bytes into a 32-bit word and flags the last byte
module byte_word_assembler
   import instruction_ram_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_clear,
   input  logic        i_shift,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_full
);
   localparam int CW = $clog2(WORD_BYTES);

   logic [CW-1:0] r_cnt;
   logic [31:0]   r_word;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt  <= '0;
         r_word <= '0;
      end else if (i_clear) begin
         r_cnt  <= '0;
         r_word <= '0;
      end else if (i_shift) begin
         r_word <= {r_word[23:0], i_byte};
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   // counter wraps to zero on the completing byte, ready for the next word
   assign o_full = i_shift && (r_cnt == CW'(WORD_BYTES - 1));
   assign o_word = r_word;
endmodule

// File: rtl/instruction_ram_loader.sv
// instruction_ram_loader: loads a length-prefixed, XOR-checked byte stream into instruction RAM
module instruction_ram_loader
   import instruction_ram_loader_pkg::*;
#(
   parameter int DEPTH      = 98,
   parameter int BASE_ADDR  = 0,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   instruction_ram_loader_if.slave     bus
);
   localparam int MAX_WORDS = DEPTH - BASE_ADDR;

   state_t                r_state, w_next;
   logic [7:0]            r_hdr_hi, r_csum;
   logic [15:0]           r_n, w_n;
   logic [ADDR_WIDTH-1:0] r_words;
   logic                  w_accept, w_start, w_full, w_last, w_wr;
   logic [31:0]           w_word;

   assign w_n      = {r_hdr_hi, bus.byte_in};
   assign w_accept = bus.byte_valid && accepts_bytes(r_state);
   assign w_start  = bus.start && (r_state inside {S_IDLE, S_DONE, S_ERROR});
   assign w_last   = (32'(r_words) + 32'd1) >= 32'(r_n);
   assign w_wr     = (r_state == S_WRITE);

   byte_word_assembler u_asm (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (w_start),
      .i_shift (w_accept && r_state == S_COLLECT),
      .i_byte  (bus.byte_in),
      .o_word  (w_word),
      .o_full  (w_full)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_hdr_hi <= '0;
         r_n      <= '0;
         r_words  <= '0;
         r_csum   <= '0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_words <= '0;
            r_csum  <= '0;
         end
         if (w_accept && r_state == S_HDR_HI) r_hdr_hi <= bus.byte_in;
         if (w_accept && r_state == S_HDR_LO) r_n <= w_n;
         if (w_accept && r_state == S_COLLECT) r_csum <= r_csum ^ bus.byte_in;
         if (w_wr) r_words <= r_words + 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    w_next = w_start ? S_HDR_HI : S_IDLE;
         S_DONE:    w_next = w_start ? S_HDR_HI : S_IDLE;
         S_ERROR:   w_next = w_start ? S_HDR_HI : S_ERROR;
         S_HDR_HI:  w_next = w_accept ? S_HDR_LO : S_HDR_HI;
         // oversize lengths are rejected before any write can leave the RAM range
         S_HDR_LO:  w_next = !w_accept ? S_HDR_LO :
                            (int'(w_n) > MAX_WORDS) ? S_ERROR :
                            (w_n == 16'd0) ? S_CHECK : S_COLLECT;
         S_COLLECT: w_next = w_full ? S_WRITE : S_COLLECT;
         S_WRITE:   w_next = w_last ? S_CHECK : S_COLLECT;
         S_CHECK:   w_next = !w_accept ? S_CHECK :
                            (bus.byte_in == r_csum) ? S_DONE : S_ERROR;
         default:   w_next = S_IDLE;
      endcase
   end

   assign bus.byte_ready   = accepts_bytes(r_state);
   assign bus.busy         = is_busy(r_state);
   assign bus.done         = (r_state == S_DONE);
   assign bus.error        = (r_state == S_ERROR);
   assign bus.wr_enable    = w_wr;
   assign bus.wr_address   = w_wr ? ADDR_WIDTH'(BASE_ADDR) + r_words : '0;
   assign bus.wr_data      = w_wr ? w_word : '0;
   assign bus.words_loaded = r_words;
endmodule

// File: tb/tb_instruction_ram_loader.sv
// tb_instruction_ram_loader: table-driven load scenarios plus reset-mid-word sequence
module tb_instruction_ram_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instruction_ram_loader_if #(.ADDR_WIDTH(10)) bus ();

   instruction_ram_loader #(
      .DEPTH      (98),
      .BASE_ADDR  (0),
      .ADDR_WIDTH (10)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   typedef struct {
      string       name;
      int          nb;
      logic [95:0] b;
      logic        gap;
      int          exp_wr;
      logic [31:0] d0;
      logic [31:0] d1;
      int          exp_done;
      logic        exp_err;
      int          exp_words;
   } vec_t;

   vec_t vecs[6];
   int checks = 0;
   int errors = 0;
   int n_wr = 0, n_done = 0, n_clash = 0;
   logic [9:0]  cap_addr[64];
   logic [31:0] cap_data[64];

   always @(negedge clk) begin
      if (bus.wr_enable) begin
         cap_addr[n_wr % 64] <= bus.wr_address;
         cap_data[n_wr % 64] <= bus.wr_data;
         n_wr <= n_wr + 1;
      end
      if (bus.done) n_done <= n_done + 1;
      if (bus.wr_enable && bus.byte_ready) n_clash <= n_clash + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic gap);
      int k = 0;
      if (gap) begin
         bus.byte_valid = 1'b0;
         @(negedge clk);
      end
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      while (!bus.byte_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: byte %h never accepted", b);
      end
      @(negedge clk);
   endtask

   task automatic run_load(input logic [95:0] b, input int nb, input logic gap);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < nb; i++) send(b[95-8*i -: 8], gap);
      bus.byte_valid = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic run_vec(input int idx);
      int w0, dn0, c0;
      vec_t v;
      v   = vecs[idx];
      w0  = n_wr;
      dn0 = n_done;
      c0  = n_clash;
      run_load(v.b, v.nb, v.gap);
      chk({v.name, " writes"}, 32'(n_wr - w0), 32'(v.exp_wr));
      for (int i = 0; i < v.exp_wr && i < 2; i++) begin
         chk({v.name, " wr_address"}, 32'(cap_addr[(w0 + i) % 64]), 32'(i));
         chk({v.name, " wr_data"}, cap_data[(w0 + i) % 64], (i == 0) ? v.d0 : v.d1);
      end
      chk({v.name, " done_pulses"}, 32'(n_done - dn0), 32'(v.exp_done));
      chk({v.name, " error"}, 32'(bus.error), 32'(v.exp_err));
      chk({v.name, " words_loaded"}, 32'(bus.words_loaded), 32'(v.exp_words));
      chk({v.name, " busy"}, 32'(bus.busy), 32'd0);
      chk({v.name, " byte_ready"}, 32'(bus.byte_ready), 32'd0);
      chk({v.name, " ready_in_write"}, 32'(n_clash - c0), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " byte_ready"}, 32'(bus.byte_ready), 32'd0);
      chk({tag, " wr_enable"}, 32'(bus.wr_enable), 32'd0);
      chk({tag, " wr_address"}, 32'(bus.wr_address), 32'd0);
      chk({tag, " wr_data"}, bus.wr_data, 32'd0);
      chk({tag, " busy"}, 32'(bus.busy), 32'd0);
      chk({tag, " done"}, 32'(bus.done), 32'd0);
      chk({tag, " error"}, 32'(bus.error), 32'd0);
      chk({tag, " words_loaded"}, 32'(bus.words_loaded), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int w0;
      vecs[0] = '{"basic", 11, {8'h00, 8'h02, 8'h6C, 8'h00, 8'h00, 8'h00, 8'h76, 8'hA0, 8'h00, 8'h00, 8'hBA, 8'h00},
                  1'b0, 2, 32'h6C000000, 32'h76A00000, 1, 1'b0, 2};
      vecs[1] = '{"empty", 3, {8'h00, 8'h00, 8'h00, 72'h0},
                  1'b0, 0, 32'h0, 32'h0, 1, 1'b0, 0};
      vecs[2] = '{"overlength", 2, {8'h00, 8'h63, 80'h0},
                  1'b0, 0, 32'h0, 32'h0, 0, 1'b1, 0};
      vecs[3] = '{"bad_csum", 11, {8'h00, 8'h02, 8'h6C, 8'h00, 8'h00, 8'h00, 8'h76, 8'hA0, 8'h00, 8'h00, 8'hBB, 8'h00},
                  1'b0, 2, 32'h6C000000, 32'h76A00000, 0, 1'b1, 2};
      vecs[4] = '{"single", 7, {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08, 40'h0},
                  1'b0, 1, 32'h12345678, 32'h0, 1, 1'b0, 1};
      vecs[5] = '{"backpressure", 11, {8'h00, 8'h02, 8'h6C, 8'h00, 8'h00, 8'h00, 8'h76, 8'hA0, 8'h00, 8'h00, 8'hBA, 8'h00},
                  1'b1, 2, 32'h6C000000, 32'h76A00000, 1, 1'b0, 2};

      bus.start      = 1'b0;
      bus.byte_in    = 8'h00;
      bus.byte_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(i);

      // reset in the middle of the first data word
      w0 = n_wr;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      send(8'h00, 1'b0);
      send(8'h02, 1'b0);
      send(8'h6C, 1'b0);
      send(8'h00, 1'b0);
      bus.byte_valid = 1'b0;
      chk("midword busy_before_reset", 32'(bus.busy), 32'd1);
      #1 rst_n = 1'b0;
      #1 chk_reset_outputs("midword");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("midword no_write", 32'(n_wr - w0), 32'd0);
      run_vec(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/instruction_ram_loader.md
INSTRUCTION_RAM_LOADER -- requirements
Module: instruction_ram_loader

Interface
REQ-001 Parameter DEPTH, default 98: number of instruction words the target RAM holds.
REQ-002 Parameter BASE_ADDR, default 0: first RAM word address written.
REQ-003 Parameter ADDR_WIDTH, default 10: width of the write address.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
REQ-007 byte_in  in  8  incoming stream byte.
REQ-008 byte_valid  in  1  byte_in holds a valid byte.
REQ-009 byte_ready  out  1  loader accepts byte_in this cycle.
REQ-010 wr_enable  out  1  one-cycle instruction RAM write strobe.
REQ-011 wr_address  out  ADDR_WIDTH  instruction RAM word address.
REQ-012 wr_data  out  32  instruction word to write.
REQ-013 busy  out  1  high from start acceptance until DONE or ERROR.
REQ-014 done  out  1  one-cycle pulse on successful load.
REQ-015 error  out  1  sticky failure flag, cleared by the next accepted start.
REQ-016 words_loaded  out  ADDR_WIDTH  count of words written in the current or last load.

Function
REQ-017 A byte is accepted in a cycle when byte_valid and byte_ready are both high.
REQ-018 The FSM SHALL use states IDLE, HDR_HI, HDR_LO, COLLECT, WRITE, CHECK, DONE and ERROR.
REQ-019 IDLE/DONE/ERROR + start: go to HDR_HI, clear error, words_loaded and the checksum; start is ignored in all other states.
REQ-020 HDR_HI/HDR_LO: accept the high and low bytes of a 16-bit word count N.
REQ-021 After HDR_LO: N > DEPTH-BASE_ADDR goes to ERROR; N = 0 goes to CHECK; otherwise go to COLLECT.
REQ-022 COLLECT: accept 4 bytes per word, big-endian (first byte is wr_data[31:24]); the 4th byte moves the FSM to WRITE.
REQ-023 WRITE: wr_enable = 1 for exactly one cycle, wr_address = BASE_ADDR + words_loaded, wr_data = the assembled word; words_loaded increments at the end of the cycle.
REQ-024 WRITE exit: go to CHECK after the Nth word, otherwise back to COLLECT.
REQ-025 byte_ready SHALL be 1 only in HDR_HI, HDR_LO, COLLECT and CHECK; it is 0 in WRITE, so each word costs at least 5 cycles.
REQ-026 Checksum = XOR of all data bytes (header excluded), updated on each accepted data byte.
REQ-027 CHECK: accept one byte; equal to the checksum goes to DONE, unequal goes to ERROR.
REQ-028 DONE: done = 1 for one cycle, busy = 0; the FSM then returns to IDLE unless start is high that cycle.
REQ-029 ERROR: error = 1 and busy = 0 until start; no further writes occur.
REQ-030 Gaps in byte_valid SHALL stall the FSM without losing state or partial words.
REQ-031 wr_address SHALL never exceed BASE_ADDR+DEPTH-1.

Reset
REQ-032 Asserting reset at any time SHALL force IDLE immediately and drive these outputs:
- byte_ready = 0, wr_enable = 0, wr_address = 0, wr_data = 0;
- busy = 0, done = 0, error = 0, words_loaded = 0.
REQ-033 A partial word or header held at reset SHALL be discarded and never written.

Structure
REQ-034 The FSM state encoding and the header/word byte-count constants SHALL live in the shared processor package.
REQ-035 A single sub-module, byte_word_assembler, SHALL shift four bytes into a 32-bit word and flag completion.

Verification
REQ-036 Bench scenario, basic load:
- stimulus: start, then bytes 00 02, 6C 00 00 00, 76 A0 00 00, BA;
- response: writes 0x6C000000 at address 0 and 0x76A00000 at address 1, done pulse, words_loaded = 2, error = 0.
REQ-037 Bench scenario, empty load: start, bytes 00 00 then 00 -> no wr_enable, done pulse, words_loaded = 0.
REQ-038 Bench scenario, over-length header: start, bytes 00 63 (N = 99, DEPTH = 98) -> ERROR right after the header, error = 1, no writes, byte_ready = 0.
REQ-039 Bench scenario, bad checksum: the basic load with final byte 0xBB -> both words written, error = 1, no done pulse.
REQ-040 Bench scenario, reset mid-word: assert reset after 2 of 4 bytes -> all outputs at reset values, no write; a following full load succeeds from address 0.
REQ-041 Bench scenario, backpressure: the basic load with byte_valid low on alternate cycles -> identical writes, and no byte accepted while in WRITE.
